data_mem_responder: RTL and testbench

Multi-cycle data-memory responder for the RISC-V core's load/store path. It accepts one word request at a time from the memory stage over a valid/ready handshake, waits a programmable number of access cycles, then returns read data or a write acknowledgement over a second valid/ready handshake. The memory array is word-addressed with byte addresses on the interface. It replaces the zero-latency array so the core can be exercised against realistic memory latency.

---
 rtl/data_mem_responder.sv | 78 +++++++
 tb/tb_data_mem_responder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle word memory behind request/response valid/ready handshakes.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned or out-of-range accesses via resp_err.
module data_mem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LATENCY > 0 ? $clog2(LATENCY + 1) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  function automatic logic [DEPTH-1:0][31:0] mem_init();
    logic [DEPTH-1:0][31:0] m;
    for (int k = 0; k < DEPTH; k++) m[k] = 32'(k);
    return m;
  endfunction
  state_t st, st_n;
  logic [CW-1:0] cnt;
  logic wr, err, fire;
  logic [31:0] addr, wdata;
  logic [AW-1:0] idx;
  logic [DEPTH-1:0][31:0] mem = mem_init();
  assign req_ready = st == IDLE;
  assign idx = addr[AW+1:2];
  assign fire = st == WAIT && cnt == '0;
`ifdef DMEM_ALIGN_CHECK_EN
  assign err = addr[1:0] != 2'b00 || |addr[31:AW+2];
`else
  logic unused_addr;
  assign err = 1'b0;
  assign unused_addr = ^{addr[1:0], addr[31:AW+2]};
`endif
  always_comb begin
    st_n = st;
    if (st == IDLE && req_valid) st_n = WAIT;
    if (fire) st_n = RESP;
    if (st == RESP && resp_ready) st_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= IDLE;
      cnt <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      st <= st_n;
      resp_valid <= st_n == RESP;
      if (st == IDLE && req_valid) cnt <= CW'(LATENCY);
      else if (st == WAIT && cnt != '0) cnt <= cnt - CW'(1);
      if (fire) begin
        resp_rdata <= (wr || err) ? '0 : mem[idx];
        resp_err <= err;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (st == IDLE && req_valid) begin
      wr <= req_write;
      addr <= req_addr;
      wdata <= req_wdata;
    end
  end
  // Commit only on the edge entering RESP so an aborted access leaves the array untouched.
  always_ff @(posedge clk) begin
    if (rst && fire && wr && !err) mem[idx] <= wdata;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench driving a LATENCY=2 and a LATENCY=0 instance.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst[2], rv[2], rw[2], rr[2], qy[2], pv[2], pe[2];
  logic [31:0] ra[2], wd[2], pd[2];
  logic [32:0] exp_q[2][$];
  int tests = 0;
  int failed = 0;
  localparam logic [32:0] ERR = 33'h1_0000_0000;
  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(128), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst[0]), .req_valid(rv[0]), .req_write(rw[0]), .req_addr(ra[0]),
    .req_wdata(wd[0]), .req_ready(qy[0]), .resp_valid(pv[0]), .resp_ready(rr[0]),
    .resp_rdata(pd[0]), .resp_err(pe[0])
  );
  data_mem_responder #(.DEPTH(128), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst[1]), .req_valid(rv[1]), .req_write(rw[1]), .req_addr(ra[1]),
    .req_wdata(wd[1]), .req_ready(qy[1]), .resp_valid(pv[1]), .resp_ready(rr[1]),
    .resp_rdata(pd[1]), .resp_err(pe[1])
  );

  function automatic logic [32:0] ok(input logic [31:0] d);
    return {1'b0, d};
  endfunction

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic access(input int g, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [32:0] e, input int lat, input int hold);
    int n;
    @(negedge clk);
    rv[g] = 1'b1; rw[g] = w; ra[g] = a; wd[g] = d; rr[g] = hold == 0;
    chk($sformatf("u%0d ready before %h", g, a), 33'(qy[g]), 33'd1);
    exp_q[g].push_back(e);
    @(posedge clk); #1;
    rv[g] = 1'b0;
    chk($sformatf("u%0d busy after accept %h", g, a), 33'(qy[g]), 33'd0);
    n = 0;
    while (pv[g] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("u%0d latency %h", g, a), 33'(n), 33'(lat + 1));
    for (int i = 0; i < hold; i++) begin
      rv[g] = 1'b1; rw[g] = 1'b1; wd[g] = 32'hBAD0BAD0;
      chk($sformatf("u%0d held data %h", g, a), {pe[g], pd[g]}, e);
      chk($sformatf("u%0d held valid", g), 33'(pv[g]), 33'd1);
      chk($sformatf("u%0d held ready", g), 33'(qy[g]), 33'd0);
      @(posedge clk); #1;
    end
    rv[g] = 1'b0;
    rr[g] = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("u%0d valid drops %h", g, a), 33'(pv[g]), 33'd0);
    chk($sformatf("u%0d idle after %h", g, a), 33'(qy[g]), 33'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b0; rv[g] = 1'b0; rw[g] = 1'b0; rr[g] = 1'b0; ra[g] = '0; wd[g] = '0;
    end
    fork
      forever begin
        logic [32:0] me;
        @(negedge clk);
        for (int g = 0; g < 2; g++)
          if (pv[g] === 1'b1 && rr[g] === 1'b1) begin
            tests++;
            if (exp_q[g].size() == 0) begin
              failed++;
              $display("FAIL u%0d response: got %h, expected none", g, {pe[g], pd[g]});
            end else begin
              me = exp_q[g].pop_front();
              if ({pe[g], pd[g]} !== me) begin
                failed++;
                $display("FAIL u%0d response: got %h, expected %h", g, {pe[g], pd[g]}, me);
              end
            end
          end
      end
    join_none
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("u%0d reset ready", g), 33'(qy[g]), 33'd1);
      chk($sformatf("u%0d reset valid", g), 33'(pv[g]), 33'd0);
      chk($sformatf("u%0d reset resp", g), {pe[g], pd[g]}, 33'd0);
      rst[g] = 1'b1;
    end
    access(0, 1'b0, 32'h20, 32'h0, ok(32'd8), 2, 0);
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, ok(32'd0), 2, 0);
    access(0, 1'b0, 32'h10, 32'h0, ok(32'hDEADBEEF), 2, 0);
    access(0, 1'b0, 32'h14, 32'h0, ok(32'd5), 2, 5);
    access(0, 1'b0, 32'h14, 32'h0, ok(32'd5), 2, 0);
    @(negedge clk);
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h08; wd[0] = 32'h55;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    chk("u0 abort valid", 33'(pv[0]), 33'd0);
    chk("u0 abort ready", 33'(qy[0]), 33'd1);
    access(0, 1'b0, 32'h08, 32'h0, ok(32'd2), 2, 0);
    access(1, 1'b0, 32'h04, 32'h0, ok(32'd1), 0, 0);
    access(1, 1'b0, 32'h08, 32'h0, ok(32'd2), 0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    access(1, 1'b0, 32'h13, 32'h0, ERR, 0, 0);
    access(1, 1'b0, 32'h200, 32'h0, ERR, 0, 0);
    access(1, 1'b1, 32'h13, 32'h12345678, ERR, 0, 0);
    access(1, 1'b0, 32'h10, 32'h0, ok(32'd4), 0, 0);
`else
    access(1, 1'b0, 32'h13, 32'h0, ok(32'd4), 0, 0);
    access(1, 1'b0, 32'h200, 32'h0, ok(32'd0), 0, 0);
    access(1, 1'b1, 32'h210, 32'hCAFEF00D, ok(32'd0), 0, 0);
    access(1, 1'b0, 32'h10, 32'h0, ok(32'hCAFEF00D), 0, 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++)
      chk($sformatf("u%0d responses outstanding", g), 33'(exp_q[g].size()), 33'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
